// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared constants, register map and payload types for the
// raster timing generator and its CPU-bus register block.
package video_timing_pkg;

    // Default raster geometry (pixels / lines), shared with testbenches.
    localparam int unsigned DEF_H_DISPLAY = 160;
    localparam int unsigned DEF_H_FRONT   = 8;
    localparam int unsigned DEF_H_SYNC    = 16;
    localparam int unsigned DEF_H_BACK    = 16;
    localparam int unsigned DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int unsigned DEF_V_DISPLAY = 128;
    localparam int unsigned DEF_V_FRONT   = 4;
    localparam int unsigned DEF_V_SYNC    = 3;
    localparam int unsigned DEF_V_BACK    = 9;
    localparam int unsigned DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned DEF_PIX_DIV   = 1;

    // Datapath widths.
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned HPOS_W  = 8;
    localparam int unsigned VPOS_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned FRAME_W = 8;

    // Register indices.
    localparam logic [ADDR_W-1:0] REG_LINE   = 2'd0;
    localparam logic [ADDR_W-1:0] REG_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CMP    = 2'd2;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 2'd3;

    // STATUS bit positions.
    localparam int unsigned ST_VBLANK  = 0;
    localparam int unsigned ST_PENDING = 1;
    localparam int unsigned ST_DISPON  = 2;

    // Registered video bundle handed to the pixel pipeline.
    typedef struct packed {
        logic              hsync;
        logic              vsync;
        logic [HPOS_W-1:0] hpos;
        logic [VPOS_W-1:0] vpos;
        logic              display_on;
    } video_t;

    // True when cnt lies in [lo, lo+len).
    function automatic logic in_range(input logic [CNT_W-1:0] cnt,
                                      input int unsigned       lo,
                                      input int unsigned       len);
        return (cnt >= CNT_W'(lo)) && (cnt < CNT_W'(lo + len));
    endfunction

endpackage

// File: rtl/video_timing_scan_counter.sv
// scan_counter: modulo-N counter with enable and a combinational terminal-count flag.
module scan_counter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_c_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc_c_o  = (count_q == W'(N - 1));
    assign count_o = count_q;

    // Advance when enabled, wrapping to zero after the terminal count.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = tc_c_o ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/video_timing.sv
// video_timing: raster timing generator with a 4-register CPU-bus peripheral
// (LINE, STATUS, CMP, CTRL). Define VIDEO_TIMING_IRQ_EN to build the
// line-compare raster interrupt; without it irq is tied low and CMP,
// STATUS.pending and CTRL.irq_en read as zero.
module video_timing
    import video_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter int unsigned PIX_DIV   = DEF_PIX_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] dout,
    output logic              hsync,
    output logic              vsync,
    output logic [HPOS_W-1:0] hpos,
    output logic [VPOS_W-1:0] vpos,
    output logic              display_on,
    output logic              irq
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned PD_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [PD_W-1:0]    pdiv;
    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               pix_en;
    logic               h_tc;
    logic               v_tc;
    logic               line_end;
    logic               frame_end;
    logic               h_vis;
    logic               v_vis;
    logic               wr_en;
    logic               rd_en;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    video_t             video_q;
    video_t             video_d;
    logic [DATA_W-1:0]  rdata_c;
    logic [DATA_W-1:0]  dout_q;
    logic [DATA_W-1:0]  dout_d;
    logic [DATA_W-1:0]  cmp_val;
    logic               pending_val;
    logic               irq_en_val;
    logic               unused_bits;

    assign line_end  = pix_en & h_tc;
    assign frame_end = line_end & v_tc;
    assign h_vis     = (hcount < CNT_W'(H_DISPLAY));
    assign v_vis     = (vcount < CNT_W'(V_DISPLAY));
    assign wr_en     = cs & ~rw;
    assign rd_en     = cs & rw;

    scan_counter #(.N(PIX_DIV), .W(PD_W)) u_pdiv (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (pdiv),
        .tc_c_o  (pix_en)
    );

    scan_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcount (
        .clk     (clk),
        .reset   (reset),
        .en_i    (pix_en),
        .count_o (hcount),
        .tc_c_o  (h_tc)
    );

    scan_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcount (
        .clk     (clk),
        .reset   (reset),
        .en_i    (line_end),
        .count_o (vcount),
        .tc_c_o  (v_tc)
    );

`ifdef VIDEO_TIMING_IRQ_EN
    logic [DATA_W-1:0] cmp_q;
    logic [DATA_W-1:0] cmp_d;
    logic              irq_en_q;
    logic              irq_en_d;
    logic              pending_q;
    logic              pending_d;
    logic              irq_q;
    logic              irq_d;
    logic [CNT_W-1:0]  vcount_next;
    logic              match;

    // Line about to start and the compare event on its first pixel.
    assign vcount_next = v_tc ? '0 : vcount + CNT_W'(1);
    assign match       = line_end && (vcount_next == CNT_W'(cmp_q));

    // Interrupt register updates; a match beats a same-cycle clear.
    always_comb begin
        cmp_d     = cmp_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        if (wr_en && (addr == REG_CMP)) begin
            cmp_d = di;
        end
        if (wr_en && (addr == REG_CTRL)) begin
            irq_en_d = di[0];
        end
        if (wr_en && (addr == REG_STATUS) && di[ST_PENDING]) begin
            pending_d = 1'b0;
        end
        if (match) begin
            pending_d = 1'b1;
        end
        irq_d = pending_d & irq_en_d;
    end

    // Interrupt state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_q     <= '0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign cmp_val     = cmp_q;
    assign pending_val = pending_q;
    assign irq_en_val  = irq_en_q;
    assign irq         = irq_q;
    assign unused_bits = ^{frame_q[FRAME_W-1], pdiv};
`else
    assign cmp_val     = '0;
    assign pending_val = 1'b0;
    assign irq_en_val  = 1'b0;
    assign irq         = 1'b0;
    assign unused_bits = ^{frame_q[FRAME_W-1], pdiv, di, wr_en};
`endif

    // Video decode of the current counters, frame count and register read mux.
    always_comb begin
        video_d            = '0;
        video_d.hsync      = in_range(hcount, H_DISPLAY + H_FRONT, H_SYNC);
        video_d.vsync      = in_range(vcount, V_DISPLAY + V_FRONT, V_SYNC);
        video_d.display_on = h_vis & v_vis;
        video_d.hpos       = h_vis ? hcount[HPOS_W-1:0] : HPOS_W'(H_DISPLAY - 1);
        video_d.vpos       = v_vis ? vcount[VPOS_W-1:0] : VPOS_W'(V_DISPLAY - 1);

        frame_d = frame_end ? frame_q + FRAME_W'(1) : frame_q;

        rdata_c = '0;
        case (addr)
            REG_LINE: rdata_c = vcount[DATA_W-1:0];
            REG_STATUS: begin
                rdata_c[ST_VBLANK]  = ~v_vis;
                rdata_c[ST_PENDING] = pending_val;
                rdata_c[ST_DISPON]  = h_vis & v_vis;
            end
            REG_CMP:  rdata_c = cmp_val;
            REG_CTRL: rdata_c = {frame_q[DATA_W-2:0], irq_en_val};
            default:  rdata_c = '0;
        endcase

        dout_d = rd_en ? rdata_c : dout_q;
    end

    // Output, frame and read-data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            video_q <= '0;
            frame_q <= '0;
            dout_q  <= '0;
        end else begin
            video_q <= video_d;
            frame_q <= frame_d;
            dout_q  <= dout_d;
        end
    end

    assign hsync      = video_q.hsync;
    assign vsync      = video_q.vsync;
    assign hpos       = video_q.hpos;
    assign vpos       = video_q.vpos;
    assign display_on = video_q.display_on;
    assign dout       = dout_q;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: table-driven register checks plus directed raster and
// interrupt sequences for video_timing (default 200x144 raster, PIX_DIV=1).
// Interrupt expectations follow VIDEO_TIMING_IRQ_EN.
module tb_video_timing;
    import video_timing_pkg::*;

    localparam int unsigned HT    = 200;
    localparam int unsigned VT    = 144;
    localparam int unsigned FRAME = HT * VT;
`ifdef VIDEO_TIMING_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       cs    = 1'b0;
    logic       rw    = 1'b1;
    logic [1:0] addr  = 2'd0;
    logic [7:0] di    = 8'd0;
    logic [7:0] dout;
    logic       hsync;
    logic       vsync;
    logic [7:0] hpos;
    logic [6:0] vpos;
    logic       display_on;
    logic       irq;

    int checks    = 0;
    int errors    = 0;
    int edges     = 0;
    int bad_video = 0;
    int first_bad = -1;
    int disp_cnt  = 0;
    int hs_cnt    = 0;
    int vs_cnt    = 0;

    typedef struct {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] di;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    video_timing dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .rw         (rw),
        .addr       (addr),
        .di         (di),
        .dout       (dout),
        .hsync      (hsync),
        .vsync      (vsync),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; outputs after edge k reflect counter k-1.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // Raster reference model, checked on the falling edge.
    int mc, mh, mv, e_hpos, e_vpos;
    bit e_hs, e_vs, e_de;
    always @(negedge clk) begin
        if (!reset && edges >= 1) begin
            mc     = edges - 1;
            mh     = mc % HT;
            mv     = (mc / HT) % VT;
            e_hs   = (mh >= 168) && (mh < 184);
            e_vs   = (mv >= 132) && (mv < 135);
            e_de   = (mh < 160) && (mv < 128);
            e_hpos = (mh < 160) ? mh : 159;
            e_vpos = (mv < 128) ? mv : 127;
            if (hsync !== e_hs || vsync !== e_vs || display_on !== e_de ||
                hpos !== 8'(e_hpos) || vpos !== 7'(e_vpos)) begin
                if (bad_video == 0) first_bad = mc;
                bad_video++;
            end
            if (mc < FRAME) begin
                if (display_on) disp_cnt++;
                if (hsync)      hs_cnt++;
                if (vsync)      vs_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; di = d;
        tick();
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; addr = a;
        tick();
        d  = dout;
        cs = 1'b0;
    endtask

    task automatic wait_until(input int target);
        int guard = 0;
        while (edges < target && guard < 200000) begin
            tick();
            guard++;
        end
        if (edges != target) begin
            errors++;
            $display("FAIL wait_edge: got %0d expected %0d", edges, target);
        end
    endtask

    task automatic count_irq_until(input int target, output int n);
        int guard = 0;
        n = 0;
        while (edges < target && guard < 200000) begin
            tick();
            guard++;
            if (irq) n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hsync"},      32'(hsync),      32'd0);
        check({tag, "_vsync"},      32'(vsync),      32'd0);
        check({tag, "_hpos"},       32'(hpos),       32'd0);
        check({tag, "_vpos"},       32'(vpos),       32'd0);
        check({tag, "_display_on"}, 32'(display_on), 32'd0);
        check({tag, "_irq"},        32'(irq),        32'd0);
        check({tag, "_dout"},       32'(dout),       32'd0);
    endtask

    logic [7:0] d;
    int         n;
    logic [7:0] c5a, cc8, cctrl1, st_pend, ctrl_f3;

    initial begin
        c5a     = IRQ ? 8'h5A : 8'h00;
        cc8     = IRQ ? 8'hC8 : 8'h00;
        cctrl1  = IRQ ? 8'h01 : 8'h00;
        st_pend = IRQ ? 8'h06 : 8'h04;
        ctrl_f3 = IRQ ? 8'h07 : 8'h06;

        //          cs    rw    addr        di     expected dout
        vecs[0]  = '{1'b1, 1'b0, REG_CMP,    8'h5A, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, REG_CMP,    8'h00, c5a};
        vecs[2]  = '{1'b0, 1'b1, REG_LINE,   8'h00, c5a};
        vecs[3]  = '{1'b1, 1'b0, REG_CMP,    8'hC8, c5a};
        vecs[4]  = '{1'b1, 1'b1, REG_CMP,    8'h00, cc8};
        vecs[5]  = '{1'b1, 1'b0, REG_CTRL,   8'hFF, cc8};
        vecs[6]  = '{1'b1, 1'b1, REG_CTRL,   8'h00, cctrl1};
        vecs[7]  = '{1'b1, 1'b0, REG_CTRL,   8'h00, cctrl1};
        vecs[8]  = '{1'b1, 1'b1, REG_CTRL,   8'h00, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, REG_STATUS, 8'hFD, 8'h00};
        vecs[10] = '{1'b1, 1'b1, REG_STATUS, 8'h00, 8'h04};
        vecs[11] = '{1'b0, 1'b1, REG_CMP,    8'h00, 8'h04};
        vecs[12] = '{1'b1, 1'b1, REG_LINE,   8'h00, 8'h00};
        vecs[13] = '{1'b1, 1'b0, REG_CMP,    8'h00, 8'h00};
        vecs[14] = '{1'b1, 1'b1, REG_CMP,    8'h00, 8'h00};

        // Power-on reset.
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 reset = 1'b0;

        // First clock after release shows the first visible pixel.
        tick();
        check("first_display_on", 32'(display_on), 32'd1);
        check("first_hpos",       32'(hpos),       32'd0);
        check("first_vpos",       32'(vpos),       32'd0);

        // Register access table; dout checked every cycle (held when not read).
        for (int i = 0; i < NVEC; i++) begin
            cs = vecs[i].cs; rw = vecs[i].rw; addr = vecs[i].addr; di = vecs[i].di;
            tick();
            check($sformatf("reg_vec%0d", i), 32'(dout), 32'(vecs[i].exp));
        end
        cs = 1'b0; rw = 1'b1;

        // Match on line 10 with a same-cycle pending clear: set wins.
        wr(REG_CMP, 8'd10);
        wr(REG_CTRL, 8'h01);
        wait_until(1999);
        check("irq_before_line10", 32'(irq), 32'd0);
        cs = 1'b1; rw = 1'b0; addr = REG_STATUS; di = 8'h02;
        tick();
        cs = 1'b0; rw = 1'b1;
        check("irq_match_vs_clear", 32'(irq), 32'(IRQ));
        rd(REG_STATUS, d);
        check("status_pending_kept", 32'(d), 32'(st_pend));
        wr(REG_STATUS, 8'h02);
        check("irq_cleared_line10", 32'(irq), 32'd0);

        // Line 64 compare, masking and clearing.
        wr(REG_CMP, 8'd64);
        wait_until(12799);
        check("irq_before_line64", 32'(irq), 32'd0);
        tick();
        check("irq_line64", 32'(irq), 32'(IRQ));
        wr(REG_CTRL, 8'h00);
        check("irq_masked", 32'(irq), 32'd0);
        rd(REG_STATUS, d);
        check("masked_pending_kept", 32'(d), 32'(st_pend));
        wr(REG_CTRL, 8'h01);
        check("irq_unmasked", 32'(irq), 32'(IRQ));
        wr(REG_STATUS, 8'h02);
        check("irq_cleared_line64", 32'(irq), 32'd0);
        count_irq_until(FRAME + 1, n);
        check("no_second_irq_frame0", 32'(n), 32'd0);

        // Frame-0 raster totals.
        check("display_on_clocks", 32'(disp_cnt), 32'd20480);
        check("hsync_clocks",      32'(hs_cnt),   32'd2304);
        check("vsync_clocks",      32'(vs_cnt),   32'd600);

        // Out-of-range compare never fires; frame count after 3 frames.
        wr(REG_CMP, 8'd200);
        count_irq_until(3 * FRAME + 1, n);
        check("cmp200_no_irq", 32'(n), 32'd0);
        rd(REG_CTRL, d);
        check("ctrl_frame3", 32'(d), 32'(ctrl_f3));

        // Asynchronous reset mid-line (hcount 100, vcount 50).
        wait_until(3 * FRAME + 50 * HT + 100);
        check("pre_reset_hpos", 32'(hpos), 32'd99);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        tick();
        check("rerelease_display_on", 32'(display_on), 32'd1);
        check("rerelease_hpos",       32'(hpos),       32'd0);
        rd(REG_CMP, d);
        check("cmp_after_reset", 32'(d), 32'd0);
        rd(REG_CTRL, d);
        check("ctrl_after_reset", 32'(d), 32'd0);

        check("video_model_mismatch_cycles", 32'(bad_video), 32'd0);
        if (bad_video != 0) $display("first bad raster cycle: %0d", first_bad);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
